stg_xt_irq_sched: RTL
=====================

// Module: stg_xt_irq_sched
// PURPOSE
//  Interrupt scheduler in front of the translate stage (stg_xt). Latches N IRQ lines, picks one
//  round-robin, waits for a macro-sequence boundary and injects one synthetic JSRui into the
//  translate input. The pending fetch word is held and re-presented after the call expansion.
// PARAMETERS
//  N_IRQ       4       interrupt sources (2..8)
//  VEC_BASE    12'h040 imm12 of vector 0
//  VEC_STRIDE  12'd4   imm12 spacing between vectors
// PORTS
//  iw_clk        in  1           clock
//  iw_rst        in  1           reset, synchronous, active-high
//  iw_irq        in  N_IRQ       level requests, sampled each cycle
//  iw_irq_mask   in  N_IRQ       1 = source enabled
//  iw_irq_en     in  1           global enable
//  iw_pc         in  `SIZE_ADDR  fetch PC
//  iw_instr      in  `SIZE_DATA  fetch word
//  iw_xt_busy    in  1           translate mid-sequence (r_busy of stg_xt)
//  iw_flush      in  1           pipeline flush
//  iw_stall      in  1           pipeline stall
//  ow_pc         out `SIZE_ADDR  PC to stg_xt
//  ow_instr      out `SIZE_DATA  word to stg_xt
//  ow_fetch_hold out 1           hold fetch (do not advance PC)
//  ow_irq_ack    out N_IRQ       one-hot ack pulse, 1 cycle
//  ow_irq_active out 1           1 from injection until expansion drained
// BEHAVIOUR
//  - Reset (iw_rst at posedge): state IDLE, pending=0, rr_ptr=0, ow_fetch_hold=0, ow_irq_ack=0,
//    ow_irq_active=0. ow_pc/ow_instr pass iw_pc/iw_instr (combinational).
//  - pending[i] <= pending[i] | iw_irq[i]; cleared only by that source's ack. Mask doesn't clear.
//  - eligible = pending & iw_irq_mask, gated by iw_irq_en. Grant: first set bit scanning from
//    rr_ptr upward, wrapping mod N_IRQ. On grant i, rr_ptr <= (i+1) mod N_IRQ.
//  - States:
//    IDLE: pass-through. eligible!=0 -> ARM.
//    ARM: pass-through. boundary = !iw_xt_busy & !iw_stall & !iw_flush. Boundary with eligible
//      still nonzero: compute grant this cycle; assert ow_fetch_hold, ow_instr = {`OPC_JSRui,
//      4'b0, imm12}, imm12 = VEC_BASE + grant*VEC_STRIDE (12-bit wrap), ow_pc = iw_pc;
//      ow_irq_ack[grant]=1, clear pending[grant] -> SEEN. eligible==0 (masked meanwhile) -> IDLE.
//    SEEN: ow_fetch_hold=1, pass-through word not consumed. iw_xt_busy=1 -> DRAIN.
//      Watchdog: 2 cycles without busy -> DRAIN.
//    DRAIN: ow_fetch_hold=1 while iw_xt_busy; busy low and !iw_stall -> IDLE, hold released that
//      cycle so the held word is accepted.
//  - ow_irq_active=1 in SEEN/DRAIN and in the ARM injection cycle.
//  - Injection is one cycle only; ack is never re-asserted while iw_stall holds the cycle
//    (boundary excludes stall).
//  - iw_flush in any state: -> IDLE, hold=0, active=0; pending kept, rr_ptr kept. A flush in the
//    injection cycle suppresses ack and pending clear.
//  - Reset mid-sequence: all state cleared as above, pending lost.
//  - Same-cycle new iw_irq[i] and ack of i: pending[i] stays 1 (set wins).
//  - No combinational path from iw_irq to ow_* except via registered pending.
// TESTING
//  1. irq=0001, mask=1111, en=1, xt idle -> ARM next cycle, then JSRui imm12=0x040, ack=0001,
//     hold 1 until busy falls.
//  2. irq=1010 together, rr_ptr=0 -> first grant src1 (imm12 0x044), then src3 (0x04C), rr_ptr=0.
//  3. irq during iw_xt_busy=1 for 3 cycles -> no injection until busy=0; injected PC = held iw_pc.
//  4. iw_stall high at boundary for 2 cycles -> injection and ack delayed 2 cycles, single ack.
//  5. Flush in SEEN -> IDLE, hold=0; pending src re-armed, re-injected once flush drops.
//  6. en=0 with pending=0100 -> stays IDLE, no ack; en=1 -> inject imm12=0x048.

Source files
------------

// File: rtl/stg_xt_irq_sched.sv
// Interrupt scheduler ahead of stg_xt: latches IRQ lines, grants round-robin and injects a
// single JSRui at a macro-sequence boundary while the pending fetch word is held.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 24
`endif
`ifndef OPC_JSRui
`define OPC_JSRui 8'hC7
`endif

module stg_xt_irq_sched #(
  parameter int          N_IRQ      = 4,
  parameter logic [11:0] VEC_BASE   = 12'h040,
  parameter logic [11:0] VEC_STRIDE = 12'd4
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic [N_IRQ-1:0]      iw_irq,
  input  logic [N_IRQ-1:0]      iw_irq_mask,
  input  logic                  iw_irq_en,
  input  logic [`SIZE_ADDR-1:0] iw_pc,
  input  logic [`SIZE_DATA-1:0] iw_instr,
  input  logic                  iw_xt_busy,
  input  logic                  iw_flush,
  input  logic                  iw_stall,
  output logic [`SIZE_ADDR-1:0] ow_pc,
  output logic [`SIZE_DATA-1:0] ow_instr,
  output logic                  ow_fetch_hold,
  output logic [N_IRQ-1:0]      ow_irq_ack,
  output logic                  ow_irq_active
);

  localparam int PTR_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, ARM, SEEN, DRAIN} state_t;

  state_t           state, next_state;
  logic [N_IRQ-1:0] pending, eligible, ack_vec;
  logic [PTR_W-1:0] rr_ptr, next_ptr, grant_idx, hi_idx, lo_idx;
  logic             hi_vld, lo_vld;
  logic             boundary, inject, wd_cnt;
  logic [11:0]      imm12;

  assign eligible = iw_irq_en ? (pending & iw_irq_mask) : '0;
  assign boundary = !iw_xt_busy && !iw_stall && !iw_flush;
  assign inject   = (state == ARM) && boundary && (|eligible);
  assign imm12    = VEC_BASE + VEC_STRIDE * 12'(grant_idx);
  assign next_ptr = (grant_idx == PTR_W'(N_IRQ - 1)) ? '0 : grant_idx + 1'b1;

  // Round-robin: lowest eligible index at or above rr_ptr, else lowest eligible overall (wrap).
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_idx = PTR_W'(i);
        lo_vld = 1'b1;
        if (PTR_W'(i) >= rr_ptr) begin
          hi_idx = PTR_W'(i);
          hi_vld = 1'b1;
        end
      end
    end
    grant_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A new request in the same cycle as its ack keeps the pending bit set.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      pending <= '0;
      rr_ptr  <= '0;
      wd_cnt  <= 1'b0;
    end else begin
      pending <= (pending & ~ack_vec) | iw_irq;
      if (inject) begin
        rr_ptr <= next_ptr;
      end
      wd_cnt <= (state == SEEN) && (next_state == SEEN);
    end
  end

  always_comb begin
    next_state = state;
    if (iw_flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (|eligible) next_state = ARM;
        ARM: begin
          if (inject)          next_state = SEEN;
          else if (~|eligible) next_state = IDLE;
        end
        SEEN:    if (iw_xt_busy || wd_cnt) next_state = DRAIN;
        DRAIN:   if (!iw_xt_busy && !iw_stall) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Flush overrides everything; the injection itself can never coincide with a flush.
  always_comb begin
    ow_pc         = iw_pc;
    ow_instr      = iw_instr;
    ow_fetch_hold = 1'b0;
    ow_irq_active = 1'b0;
    ack_vec       = '0;
    if (!iw_flush) begin
      case (state)
        ARM: begin
          if (inject) begin
            ow_instr      = {`OPC_JSRui, 4'b0000, imm12};
            ow_fetch_hold = 1'b1;
            ow_irq_active = 1'b1;
            ack_vec       = N_IRQ'(1) << grant_idx;
          end
        end
        SEEN: begin
          ow_fetch_hold = 1'b1;
          ow_irq_active = 1'b1;
        end
        DRAIN: begin
          ow_fetch_hold = iw_xt_busy || iw_stall;
          ow_irq_active = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ow_irq_ack = ack_vec;

endmodule
